// File: rtl/batcharger_adc_seq.sv
// Battery-charger ADC sequencer: time-multiplexes one shared 8-bit ADC
// across the voltage, current and temperature channels in round-robin
// order, and keeps the latest sample of each together with a freshness flag.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | pick the next requested channel after the last-serviced one
// SETTLE | adc_sel driven, waiting for the input mux to settle
// START  | one-cycle adc_start pulse, arm the timeout counter
// WAIT   | waiting for adc_done, or for the timeout to expire
module batcharger_adc_seq #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       vmonen,
  input  logic       imonen,
  input  logic       tmonen,
  output logic [1:0] adc_sel,
  output logic       adc_start,
  input  logic       adc_done,
  input  logic [7:0] adc_data,
  output logic [7:0] vbat,
  output logic [7:0] ibat,
  output logic [7:0] tbat,
  output logic       vtok,
  output logic       err
);

  localparam logic [1:0] CH_V = 2'd0;
  localparam logic [1:0] CH_I = 2'd1;
  localparam logic [1:0] CH_T = 2'd2;

  // Down-counters stop at zero; the terminal count is the exit condition.
  localparam logic [3:0] SETTLE_LOAD  = 4'(SETTLE_CYC - 1);
  localparam logic [7:0] TIMEOUT_LOAD = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, START, WAIT} state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] sel_nxt;
  logic [1:0] pick;
  logic [3:0] settle_cnt, settle_nxt;
  logic [7:0] tmo_cnt, tmo_nxt;
  logic [2:0] req;
  logic [2:0] sel_oh;
  logic [2:0] valid, valid_nxt;
  logic       store;

  assign req    = {tmonen, imonen, vmonen} & {3{en}};
  assign sel_oh = 3'b001 << adc_sel;

  // Round-robin pick: first requested channel strictly after the pointer.
  always_comb begin
    pick = CH_V;
    case (ptr)
      CH_V:    pick = req[1] ? CH_I : (req[2] ? CH_T : CH_V);
      CH_I:    pick = req[2] ? CH_T : (req[0] ? CH_V : CH_I);
      default: pick = req[0] ? CH_V : (req[1] ? CH_I : CH_T);
    endcase
  end

  // Next-state, counter and strobe logic; dropping en always parks in IDLE.
  always_comb begin
    state_nxt  = state;
    sel_nxt    = adc_sel;
    ptr_nxt    = ptr;
    settle_nxt = settle_cnt;
    tmo_nxt    = tmo_cnt;
    store      = 1'b0;
    err        = 1'b0;
    adc_start  = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req != '0) begin
            sel_nxt    = pick;
            settle_nxt = SETTLE_LOAD;
            state_nxt  = SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) state_nxt = START;
          else                  settle_nxt = settle_cnt - 4'd1;
        end
        START: begin
          adc_start = 1'b1;
          tmo_nxt   = TIMEOUT_LOAD;
          state_nxt = WAIT;
        end
        WAIT: begin
          if (adc_done) begin
            // Data for a channel dropped mid-conversion is discarded.
            store     = |(req & sel_oh);
            ptr_nxt   = adc_sel;
            state_nxt = IDLE;
          end else if (tmo_cnt == '0) begin
            err       = 1'b1;
            ptr_nxt   = adc_sel;
            state_nxt = IDLE;
          end else begin
            tmo_nxt = tmo_cnt - 8'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Freshness: unrequested channels lose validity, stores set it, timeouts clear it.
  always_comb begin
    valid_nxt = valid & req;
    if (store) valid_nxt = valid_nxt | sel_oh;
    if (err)   valid_nxt = valid_nxt & ~sel_oh;
  end

  // Sequencer state, pointer, counters and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      adc_sel    <= CH_V;
      ptr        <= CH_T;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      valid      <= '0;
      vtok       <= 1'b0;
    end else begin
      state      <= state_nxt;
      adc_sel    <= sel_nxt;
      ptr        <= ptr_nxt;
      settle_cnt <= settle_nxt;
      tmo_cnt    <= tmo_nxt;
      valid      <= valid_nxt;
      vtok       <= (req != '0) && ((valid_nxt & req) == req);
    end
  end

  // Per-channel result registers; values survive timeouts and en drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vbat <= '0;
      ibat <= '0;
      tbat <= '0;
    end else if (store) begin
      case (adc_sel)
        CH_V:    vbat <= adc_data;
        CH_I:    ibat <= adc_data;
        default: tbat <= adc_data;
      endcase
    end
  end

endmodule

// File: tb/tb_batcharger_adc_seq.sv
// Bench for batcharger_adc_seq: an ADC model answers conversions with
// random data and delays; a channel-level reference model predicts the pick
// order, timing and stored values, and a scoreboard monitor checks results.
module tb_batcharger_adc_seq;

  localparam int SETTLE_CYC  = 4;
  localparam int TIMEOUT_CYC = 64;
  localparam int CH_V = 0;
  localparam int CH_I = 1;
  localparam int CH_T = 2;
  localparam int EV_STORE  = 0;
  localparam int EV_ERR    = 1;
  localparam int EV_IGNORE = 2;

  logic       clk, rst, en, vmonen, imonen, tmonen, adc_done;
  logic [7:0] adc_data;
  logic [1:0] adc_sel;
  logic       adc_start, vtok, err;
  logic [7:0] vbat, ibat, tbat;

  batcharger_adc_seq #(.SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst), .en(en),
    .vmonen(vmonen), .imonen(imonen), .tmonen(tmonen),
    .adc_sel(adc_sel), .adc_start(adc_start),
    .adc_done(adc_done), .adc_data(adc_data),
    .vbat(vbat), .ibat(ibat), .tbat(tbat),
    .vtok(vtok), .err(err)
  );

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] rv, ri, rt;
    logic       vt;
  } exp_t;

  exp_t       sbq[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         ptr_m;
  logic [7:0] reg_m[3];
  bit         valid_m[3];
  int         exp_start;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc <= cyc + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] req_now();
    return {tmonen, imonen, vmonen} & {3{en}};
  endfunction

  function automatic int next_ch(int ptr, logic [2:0] req);
    int r = -1;
    for (int k = 3; k >= 1; k--) if (req[(ptr + k) % 3]) r = (ptr + k) % 3;
    return r;
  endfunction

  function automatic logic model_vtok();
    logic [2:0] r;
    logic [2:0] v;
    r = req_now();
    v = {valid_m[2], valid_m[1], valid_m[0]};
    return (r != 3'b000) && ((v & r) == r);
  endfunction

  task automatic model_reset();
    ptr_m = CH_T;
    for (int c = 0; c < 3; c++) begin
      reg_m[c]   = 8'h00;
      valid_m[c] = 1'b0;
    end
  endtask

  task automatic set_req(bit e, bit v, bit i, bit t);
    logic [2:0] r;
    en = e; vmonen = v; imonen = i; tmonen = t;
    r = req_now();
    for (int c = 0; c < 3; c++) if (!r[c]) valid_m[c] = 1'b0;
  endtask

  task automatic push(int kind, int at);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    e.rv   = reg_m[0];
    e.ri   = reg_m[1];
    e.rt   = reg_m[2];
    e.vt   = model_vtok();
    sbq.push_back(e);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    exp_t pend;
    bit   have;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have = 1'b0;
      end else begin
        if (have) begin
          check("vbat_after_event", vbat, pend.rv);
          check("ibat_after_event", ibat, pend.ri);
          check("tbat_after_event", tbat, pend.rt);
          check("vtok_after_event", vtok, pend.vt);
          have = 1'b0;
        end
        if (adc_done || err) begin
          if (sbq.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_event: got done=%0b err=%0b with nothing expected (cycle %0d)",
                     adc_done, err, cyc);
          end else begin
            pend = sbq.pop_front();
            check("event_is_err", err, pend.kind == EV_ERR);
            check("event_cycle", cyc, pend.cyc);
            have = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- ADC model / stimulus ----------------
  task automatic wait_start(output int ch, output int s, output bit seen);
    ch   = next_ch(ptr_m, req_now());
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = adc_start;
    end
    s = cyc;
    check("start_seen", seen, 1);
    if (seen) begin
      check("start_cycle", s, exp_start);
      check("adc_sel_pick", adc_sel, ch);
    end
  endtask

  task automatic convert(int delay, bit answer, logic [7:0] data);
    int ch, s;
    bit seen;
    bit stable;
    stable = 1'b1;
    wait_start(ch, s, seen);
    if (!seen) return;
    if (answer) begin
      for (int k = 1; k <= delay; k++) begin
        @(posedge clk); #1;
        if (k == delay) begin
          logic [2:0] r;
          adc_done = 1'b1;
          adc_data = data;
          r = req_now();
          if (r[ch]) begin
            reg_m[ch]   = data;
            valid_m[ch] = 1'b1;
          end
          ptr_m = ch;
          push(EV_STORE, cyc);
          exp_start = cyc + SETTLE_CYC + 2;
        end
        @(negedge clk);
        if (adc_sel !== 2'(ch) || adc_start !== 1'b0) stable = 1'b0;
      end
      @(posedge clk); #1;
      adc_done = 1'b0;
      adc_data = 8'($urandom);
    end else begin
      valid_m[ch] = 1'b0;
      ptr_m = ch;
      push(EV_ERR, s + TIMEOUT_CYC);
      for (int k = 1; k <= TIMEOUT_CYC; k++) begin
        @(negedge clk);
        if (adc_sel !== 2'(ch) || adc_start !== 1'b0) stable = 1'b0;
      end
      exp_start = s + TIMEOUT_CYC + SETTLE_CYC + 2;
      @(posedge clk); #1;
    end
    check("sel_stable_no_restart", stable, 1);
  endtask

  initial begin
    int ch, s, i_miss;
    bit seen, quiet;

    rst = 1'b1; en = 1'b0; vmonen = 1'b0; imonen = 1'b0; tmonen = 1'b0;
    adc_done = 1'b0; adc_data = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_adc_sel", adc_sel, 0);
    check("rst_adc_start", adc_start, 0);
    check("rst_vbat", vbat, 0);
    check("rst_ibat", ibat, 0);
    check("rst_tbat", tbat, 0);
    check("rst_vtok", vtok, 0);
    check("rst_err", err, 0);

    // V and T requested: V, T, V, T with fixed 10-cycle answers.
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(1, 1, 0, 1);
    exp_start = cyc + SETTLE_CYC + 1;
    convert(10, 1, 8'hA0);
    convert(10, 1, 8'h55);
    convert(10, 1, 8'($urandom));
    convert(10, 1, 8'($urandom));

    // CV mode: I and T requested, V dropped.
    set_req(1, 0, 1, 1);
    @(posedge clk); @(negedge clk);
    check("vtok_drop_new_req", vtok, 0);
    for (int n = 0; n < 4; n++) convert($urandom_range(1, 30), 1, 8'($urandom));
    check("vbat_retained", vbat, reg_m[CH_V]);

    // All three channels requested.
    set_req(1, 1, 1, 1);
    @(posedge clk); @(negedge clk);
    check("vtok_drop_v_back", vtok, 0);
    for (int n = 0; n < 6; n++) convert($urandom_range(1, 30), 1, 8'($urandom));

    // The ADC ignores the first I conversion; the next I pick is retried.
    i_miss = 0;
    for (int n = 0; n < 5; n++) begin
      int c;
      c = next_ch(ptr_m, req_now());
      convert($urandom_range(1, 30), !(c == CH_I && i_miss == 0), 8'($urandom));
      if (c == CH_I) i_miss++;
    end
    check("i_retried", i_miss, 2);

    // en dropped during WAIT, then a late answer of 0xFF.
    wait_start(ch, s, seen);
    repeat (3) @(posedge clk);
    #1;
    set_req(0, 1, 1, 1);
    @(posedge clk); @(negedge clk);
    check("vtok_en_low", vtok, 0);
    @(posedge clk); #1;
    adc_done = 1'b1;
    adc_data = 8'hFF;
    push(EV_IGNORE, cyc);
    @(posedge clk); #1;
    adc_done = 1'b0;
    quiet = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (adc_start !== 1'b0) quiet = 1'b0;
    end
    check("idle_while_disabled", quiet, 1);
    @(posedge clk); #1;
    set_req(1, 1, 1, 1);
    exp_start = cyc + SETTLE_CYC + 1;
    convert($urandom_range(1, 30), 1, 8'($urandom));
    convert($urandom_range(1, 30), 1, 8'($urandom));

    // Reset pulsed during SETTLE of a non-V channel.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("sel_before_rst", adc_sel, next_ch(ptr_m, req_now()));
    rst = 1'b1;
    #2;
    check("async_rst_adc_sel", adc_sel, 0);
    check("async_rst_vbat", vbat, 0);
    check("async_rst_ibat", ibat, 0);
    check("async_rst_tbat", tbat, 0);
    check("async_rst_vtok", vtok, 0);
    check("async_rst_start", adc_start, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_start = cyc + SETTLE_CYC + 1;
    convert($urandom_range(1, 30), 1, 8'($urandom));
    check("first_after_rst_is_v", ptr_m, CH_V);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
